// File: rtl/bg_tile_fetcher.sv
// bg_tile_fetcher: background tile fetch sequencer.
// Reads the nametable byte for a tile, then the low and high pattern-plane
// bytes for one row of it, over a shared req/valid VRAM read port. The three
// bytes are presented together with a one-cycle tile_valid pulse.
// Optional build macro: ATTR_FETCH_EN adds an attribute-table fetch after the
// nametable read and drives palette_sel from the selected quadrant bits.
module bg_tile_fetcher #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] nametable_ptr,
  input  logic [2:0]        pattern_table_offset,
  input  logic [7:0]        ppu_ctrl1,
  input  logic              flush,
  output logic              vram_rd_req,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic              vram_rd_valid,
  input  logic [DATA_W-1:0] vram_rd_data,
  output logic              busy,
  output logic              tile_valid,
  output logic [7:0]        tile_index,
  output logic [7:0]        tile_lo,
  output logic [7:0]        tile_hi,
  output logic [1:0]        palette_sel,
  output logic [2:0]        fsm_state
);

  // Read handshake: vram_rd_req is high in every fetch state and vram_addr is
  // held constant while it is high. A read completes on the clock edge where
  // vram_rd_valid is sampled high; vram_rd_data is captured on that same edge
  // and the next address is loaded. vram_rd_valid with vram_rd_req low, or in
  // the same cycle as flush, is ignored.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NT    = 3'd1,
    S_AT    = 3'd2,
    S_PT_LO = 3'd3,
    S_PT_HI = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_d;
  logic              accept;
  logic              capture;

  // Request context latched when a fetch is accepted
  logic [ADDR_W-1:0] ptr_q;
  logic [2:0]        offset_q;
  logic              sel_q;

  // Bytes collected during the fetch, published together at DONE
  logic [7:0]        idx_q;
  logic [7:0]        lo_q;

  logic              unused_bits;

  // Pattern-table row address: table select, tile index, plane bit 0, fine row
  function automatic logic [ADDR_W-1:0] pt_addr(input logic sel,
                                                 input logic [7:0] idx,
                                                 input logic [2:0] row);
    pt_addr        = '0;
    pt_addr[12]    = sel;
    pt_addr[11:4]  = idx;
    pt_addr[3]     = 1'b0;
    pt_addr[2:0]   = row;
  endfunction

`ifdef ATTR_FETCH_EN
  logic [7:0]        attr_q;
  logic [ADDR_W-1:0] at_addr;
  logic [2:0]        quad_shift;
  logic [1:0]        palette_q;

  // Attribute byte covering this tile, and the 2-bit quadrant within it
  assign at_addr    = {ptr_q[ADDR_W-1:10], 4'b1111, ptr_q[9:7], ptr_q[4:2]};
  assign quad_shift = {ptr_q[6], ptr_q[1], 1'b0};
  assign palette_sel = palette_q;
`else
  assign palette_sel = 2'b00;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, next read address and capture strobes
  always_comb begin
    state_d = state_q;
    addr_d  = vram_addr;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_NT;
          addr_d  = nametable_ptr;
        end
      end
      S_NT: begin
        if (vram_rd_valid) begin
          capture = 1'b1;
`ifdef ATTR_FETCH_EN
          state_d = S_AT;
          addr_d  = at_addr;
`else
          state_d = S_PT_LO;
          addr_d  = pt_addr(sel_q, vram_rd_data[7:0], offset_q);
`endif
        end
      end
`ifdef ATTR_FETCH_EN
      S_AT: begin
        if (vram_rd_valid) begin
          capture = 1'b1;
          state_d = S_PT_LO;
          addr_d  = pt_addr(sel_q, idx_q, offset_q);
        end
      end
`endif
      S_PT_LO: begin
        if (vram_rd_valid) begin
          capture   = 1'b1;
          state_d   = S_PT_HI;
          addr_d    = vram_addr;
          addr_d[3] = 1'b1;
        end
      end
      S_PT_HI: begin
        if (vram_rd_valid) begin
          capture = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything, including a start or a completing read
    if (flush) begin
      state_d = S_IDLE;
      addr_d  = vram_addr;
      accept  = 1'b0;
      capture = 1'b0;
    end
  end

  // Address register, request context and captured data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vram_addr  <= '0;
      ptr_q      <= '0;
      offset_q   <= '0;
      sel_q      <= 1'b0;
      idx_q      <= '0;
      lo_q       <= '0;
      tile_index <= '0;
      tile_lo    <= '0;
      tile_hi    <= '0;
`ifdef ATTR_FETCH_EN
      attr_q     <= '0;
      palette_q  <= '0;
`endif
    end else begin
      vram_addr <= addr_d;
      if (accept) begin
        ptr_q    <= nametable_ptr;
        offset_q <= pattern_table_offset;
        sel_q    <= ppu_ctrl1[4];
      end
      if (capture) begin
        case (state_q)
          S_NT:    idx_q <= vram_rd_data[7:0];
`ifdef ATTR_FETCH_EN
          S_AT:    attr_q <= vram_rd_data[7:0];
`endif
          S_PT_LO: lo_q <= vram_rd_data[7:0];
          S_PT_HI: begin
            tile_index <= idx_q;
            tile_lo    <= lo_q;
            tile_hi    <= vram_rd_data[7:0];
`ifdef ATTR_FETCH_EN
            palette_q  <= attr_q[quad_shift +: 2];
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign vram_rd_req = (state_q == S_NT) || (state_q == S_AT) ||
                       (state_q == S_PT_LO) || (state_q == S_PT_HI);
  assign busy        = (state_q != S_IDLE);
  assign tile_valid  = (state_q == S_DONE);
  assign fsm_state   = state_q;

  // Only the table-select bit of ppu_ctrl1 matters; ptr_q is partly unused
  // depending on the build
  assign unused_bits = ^{ppu_ctrl1[7:5], ppu_ctrl1[3:0], ptr_q};

endmodule
